fetch_unit: RTL and testbench

- Front-end fetch stage. Owns the architectural fetch PC and drives it to branch_predictor_top.
- Issues in-order instruction-memory requests and selects the next PC from the same-cycle prediction.
- Pairs each memory response with its PC and prediction, then buffers the result in a small fetch queue for decode.
- Handles redirects from execute: flushes buffered state and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage. Owns the fetch PC, issues in-order
// imem requests, pairs responses with PC/prediction into a fetch queue.
// Ports: clk/rst_n; bp_* predictor lookup; imem_req_*/imem_resp_* memory;
// redirect_* from execute; fq_* fetch-queue head toward decode.
module fetch_unit #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] bp_pc_o,
  input  logic        bp_taken_i,
  input  logic [63:0] bp_target_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        fq_valid_o,
  input  logic        fq_ready_i,
  output logic [63:0] fq_pc_o,
  output logic [31:0] fq_instr_o,
  output logic        fq_pred_taken_o,
  output logic [63:0] fq_pred_target_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] QD_W = (CW+1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic        taken;
    logic [63:0] next;
  } meta_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [63:0] next;
  } fq_t;

  meta_t meta_mem [QUEUE_DEPTH];
  fq_t   fq_mem   [QUEUE_DEPTH];

  logic [63:0] pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] meta_wp_q, meta_wp_d;
  logic [PW-1:0] meta_rp_q, meta_rp_d;
  logic [CW-1:0] meta_cnt_q, meta_cnt_d;
  logic [PW-1:0] fq_wp_q, fq_wp_d;
  logic [PW-1:0] fq_rp_q, fq_rp_d;
  logic [CW-1:0] fq_cnt_q, fq_cnt_d;

  logic        req_valid;
  logic        req_fire;
  logic        keep_resp;
  logic        fq_pop;
  logic [63:0] next_pc;
  logic [CW:0] credit_used;
  meta_t       meta_head;
  fq_t         fq_head;
  logic        unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc_i[1:0];

  assign bp_pc_o         = pc_q;
  assign imem_req_addr_o = pc_q;

  // Credits count both in-flight and queued slots, so every
  // accepted request is guaranteed a fetch-queue slot.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fq_cnt_q};
  assign req_valid   = rst_n && !redirect_valid_i
                       && (credit_used < QD_W);
  assign imem_req_valid_o = req_valid;
  assign req_fire    = req_valid && imem_req_ready_i;

  assign next_pc   = bp_taken_i ? bp_target_i : pc_q + 64'd4;
  assign meta_head = meta_mem[meta_rp_q];
  assign fq_head   = fq_mem[fq_rp_q];

  assign keep_resp = imem_resp_valid_i && !redirect_valid_i
                     && (discard_q == '0);
  assign fq_pop    = fq_valid_o && fq_ready_i && !redirect_valid_i;

  assign fq_valid_o       = (fq_cnt_q != '0);
  assign fq_pc_o          = fq_valid_o ? fq_head.pc    : '0;
  assign fq_instr_o       = fq_valid_o ? fq_head.instr : '0;
  assign fq_pred_taken_o  = fq_valid_o && fq_head.taken;
  assign fq_pred_target_o = fq_valid_o ? fq_head.next  : '0;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(req_fire)
                 - CW'(imem_resp_valid_i);
    discard_d  = discard_q;
    meta_wp_d  = meta_wp_q;
    meta_rp_d  = meta_rp_q;
    meta_cnt_d = meta_cnt_q;
    fq_wp_d    = fq_wp_q;
    fq_rp_d    = fq_rp_q;
    fq_cnt_d   = fq_cnt_q;
    if (redirect_valid_i) begin
      pc_d       = {redirect_pc_i[63:2], 2'b00};
      // Everything still outstanding (minus a response landing
      // now, which is itself dropped) belongs to the old path.
      discard_d  = inflight_q - CW'(imem_resp_valid_i);
      meta_wp_d  = '0;
      meta_rp_d  = '0;
      meta_cnt_d = '0;
      fq_wp_d    = '0;
      fq_rp_d    = '0;
      fq_cnt_d   = '0;
    end else begin
      if (req_fire) pc_d = next_pc;
      if (imem_resp_valid_i && discard_q != '0)
        discard_d = discard_q - CW'(1);
      if (req_fire) meta_wp_d = meta_wp_q + PW'(1);
      if (keep_resp) meta_rp_d = meta_rp_q + PW'(1);
      meta_cnt_d = meta_cnt_q + CW'(req_fire) - CW'(keep_resp);
      if (keep_resp) fq_wp_d = fq_wp_q + PW'(1);
      if (fq_pop) fq_rp_d = fq_rp_q + PW'(1);
      fq_cnt_d = fq_cnt_q + CW'(keep_resp) - CW'(fq_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      meta_wp_q  <= '0;
      meta_rp_q  <= '0;
      meta_cnt_q <= '0;
      fq_wp_q    <= '0;
      fq_rp_q    <= '0;
      fq_cnt_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      meta_wp_q  <= meta_wp_d;
      meta_rp_q  <= meta_rp_d;
      meta_cnt_q <= meta_cnt_d;
      fq_wp_q    <= fq_wp_d;
      fq_rp_q    <= fq_rp_d;
      fq_cnt_q   <= fq_cnt_d;
    end
  end

  // Storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    if (req_fire)
      meta_mem[meta_wp_q] <= '{pc: pc_q, taken: bp_taken_i,
                               next: next_pc};
    if (keep_resp)
      fq_mem[fq_wp_q] <= '{pc: meta_head.pc,
                           instr: imem_resp_data_i,
                           taken: meta_head.taken,
                           next: meta_head.next};
  end

`ifndef SYNTHESIS
  a_discard_le_inflight: assert property (
    @(posedge clk) disable iff (!rst_n)
    discard_q <= inflight_q);
  a_meta_count: assert property (
    @(posedge clk) disable iff (!rst_n)
    meta_cnt_q == inflight_q - discard_q);
  a_credit: assert property (
    @(posedge clk) disable iff (!rst_n)
    credit_used <= QD_W);
  a_resp_has_req: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_resp_valid_i |-> inflight_q != '0);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// Memory/predictor models drive the DUT; a monitor checks fq pops.
module tb_fetch_unit;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam int D = 4;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] bp_pc_o;
  logic        bp_taken_i;
  logic [63:0] bp_target_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        fq_valid_o;
  logic        fq_ready_i;
  logic [63:0] fq_pc_o;
  logic [31:0] fq_instr_o;
  logic        fq_pred_taken_o;
  logic [63:0] fq_pred_target_o;

  fetch_unit #(.QUEUE_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .bp_pc_o(bp_pc_o), .bp_taken_i(bp_taken_i),
    .bp_target_i(bp_target_i),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i(imem_resp_data_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i),
    .fq_valid_o(fq_valid_o), .fq_ready_i(fq_ready_i),
    .fq_pc_o(fq_pc_o), .fq_instr_o(fq_instr_o),
    .fq_pred_taken_o(fq_pred_taken_o),
    .fq_pred_target_o(fq_pred_target_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [63:0] next;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int          rdy;
  } mreq_t;

  exp_t  sb[$];
  mreq_t mq[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] model_pc;
  int fq_n;
  int stale;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  function automatic logic pred_taken(logic [63:0] a);
    return a[4:2] == 3'd3;
  endfunction

  function automatic logic [63:0] pred_tgt(logic [63:0] a);
    return a + 64'h40 + 64'(a[9:8]) * 64'h80;
  endfunction

  always_comb begin
    bp_taken_i  = pred_taken(bp_pc_o);
    bp_target_i = pred_tgt(bp_pc_o);
  end

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_pc_i     = '0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
    #1;
    check("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    check("rst_fq_valid", 64'(fq_valid_o), 64'd0);
    check("rst_fq_pc", fq_pc_o, 64'd0);
    check("rst_fq_instr", 64'(fq_instr_o), 64'd0);
    check("rst_fq_target", fq_pred_target_o, 64'd0);
    check("rst_bp_pc", bp_pc_o, RPC);
    mq.delete();
    sb.delete();
    fq_n     = 0;
    stale    = 0;
    model_pc = RPC;
  endtask

  // Monitor: compare every accepted fq pop against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && fq_valid_o && fq_ready_i
          && !redirect_valid_i) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL fq_unexpected: got pc %h expected none",
                   fq_pc_o);
        end else begin
          e = sb.pop_front();
          check("fq_pc", fq_pc_o, e.pc);
          check("fq_instr", 64'(fq_instr_o), 64'(e.instr));
          check("fq_taken", 64'(fq_pred_taken_o), 64'(e.taken));
          check("fq_target", fq_pred_target_o, e.next);
        end
      end
    end
  end

  // Driver plus spec-level model of memory, credits and redirects.
  initial begin
    int phase;
    int lat;
    logic exp_valid;
    logic rsp;
    logic t;
    logic [63:0] nx;
    fq_ready_i       = 1'b0;
    imem_req_ready_i = 1'b0;
    @(negedge clk);
    do_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      if (cyc == 2500) begin
        do_reset();
        continue;
      end
      phase = (cyc / 250) % 4;
      redirect_valid_i = (phase == 2) ? ($urandom % 6 == 0)
                                      : ($urandom % 40 == 0);
      case ($urandom % 4)
        0: redirect_pc_i = 64'h0000_0000_9000_0003;
        1: redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF9;
        default: redirect_pc_i = {32'h0, $urandom};
      endcase
      fq_ready_i = (phase == 1) ? ($urandom % 8 == 0)
                                : ($urandom % 4 != 0);
      imem_req_ready_i = ($urandom % 4 != 0);
      if (mq.size() > 0 && mq[0].rdy <= cyc
          && $urandom % 3 != 0) begin
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = mem_word(mq[0].addr);
      end else begin
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i  = $urandom;
      end
      #1;
      exp_valid = !redirect_valid_i && (mq.size() + fq_n < D);
      check("req_valid", 64'(imem_req_valid_o), 64'(exp_valid));
      if (imem_req_valid_o) begin
        check("req_addr", imem_req_addr_o, model_pc);
        check("bp_pc", bp_pc_o, model_pc);
      end
      rsp = imem_resp_valid_i;
      if (redirect_valid_i) begin
        stale    = mq.size() - int'(rsp);
        fq_n     = 0;
        sb.delete();
        model_pc = {redirect_pc_i[63:2], 2'b00};
      end else begin
        if (rsp) begin
          if (stale > 0) stale--;
          else fq_n++;
        end
        if (fq_valid_o && fq_ready_i) fq_n--;
        if (imem_req_valid_o && imem_req_ready_i) begin
          t  = pred_taken(model_pc);
          nx = t ? pred_tgt(model_pc) : model_pc + 64'd4;
          sb.push_back('{model_pc, mem_word(model_pc), t, nx});
          model_pc = nx;
        end
      end
      if (rsp) void'(mq.pop_front());
      if (imem_req_valid_o && imem_req_ready_i) begin
        lat = (phase == 3) ? int'($urandom_range(3, 6))
                           : int'($urandom_range(1, 2));
        mq.push_back('{imem_req_addr_o, cyc + lat});
      end
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
